// File: rtl/rc_ctrl_pkg.sv
// Shared definitions for the RC control path: frame header bytes, frame
// parser state encoding and the neutral command values also used by the
// downstream PWM stage.
package rc_ctrl_pkg;

    localparam logic [7:0] HDR0 = 8'h61;  // 'a'
    localparam logic [7:0] HDR1 = 8'h62;  // 'b'
    localparam logic [7:0] HDR2 = 8'h63;  // 'c'

    localparam logic [15:0] STEER_NEUTRAL = 16'd500;
    localparam logic [15:0] THR_NEUTRAL   = 16'd512;

    typedef enum logic [2:0] {
        H0 = 3'd0,
        H1 = 3'd1,
        H2 = 3'd2,
        SH = 3'd3,
        SL = 3'd4,
        TH = 3'd5,
        TL = 3'd6,
        CK = 3'd7
    } frame_state_t;

    // Frame checksum: XOR of the four payload bytes.
    function automatic logic [7:0] payload_xor(input logic [15:0] steer_w,
                                               input logic [15:0] thr_w);
        return steer_w[15:8] ^ steer_w[7:0] ^ thr_w[15:8] ^ thr_w[7:0];
    endfunction

endpackage

// File: rtl/rc_frame_parser_cycle_timer.sv
// Generic 32-bit cycle timer: clears on i_clr, counts while i_en, and
// emits a single-cycle o_tc on the cycle whose count step reaches LIMIT.
// The count saturates at LIMIT so the terminal pulse fires only once per
// run; a clear always wins over the terminal pulse.
module cycle_timer #(
    parameter logic [31:0] LIMIT = 32'd100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [31:0] r_count;
    logic [31:0] w_next;

    assign w_next = r_count + 32'd1;
    assign o_tc   = i_en && !i_clr && (r_count < LIMIT) && (w_next >= LIMIT);

    // Count enabled cycles, holding at LIMIT until the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count < LIMIT)) begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/rc_frame_parser.sv
// RC control frame parser: assembles "abc" + steer(16) + throttle(16) +
// checksum frames from the UART byte stream, publishes validated commands
// with a one-cycle update strobe, aborts stalled frames after an inter-byte
// timeout and forces neutral commands when no good frame arrives in time.
module rc_frame_parser
    import rc_ctrl_pkg::*;
#(
    parameter logic [31:0] BYTE_TIMEOUT_CYC = 32'd260000,
    parameter logic [31:0] FAILSAFE_CYC     = 32'd25000000,
    parameter logic [15:0] STEER_MAX        = 16'd2000,
    parameter logic [15:0] THR_MAX          = 16'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] steer,
    output logic [15:0] throttle,
    output logic        cmd_update,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        failsafe
);

    frame_state_t r_state;
    logic [15:0]  r_steer_buf;
    logic [15:0]  r_thr_buf;
    logic [15:0]  r_steer;
    logic [15:0]  r_throttle;
    logic         r_cmd_update;
    logic         r_frame_err;
    logic         r_timeout_err;
    logic         r_failsafe;

    logic w_in_ck;
    logic w_frame_ok;
    logic w_accept;
    logic w_reject;
    logic w_byte_en;
    logic w_byte_tc;
    logic w_fs_en;
    logic w_fs_tc;

    // The checksum byte is judged against the buffers as they stand when it
    // arrives; the buffers are complete by then.
    assign w_in_ck    = rx_valid && (r_state == CK);
    assign w_frame_ok = (rx_data == payload_xor(r_steer_buf, r_thr_buf)) &&
                        (r_steer_buf <= STEER_MAX) &&
                        (r_thr_buf <= THR_MAX);
    assign w_accept   = w_in_ck && w_frame_ok;
    assign w_reject   = w_in_ck && !w_frame_ok;

    // Byte timer only runs once a frame has started (any state past H0).
    assign w_byte_en  = (r_state != H0);
    // Failsafe timer runs only while the link is considered alive.
    assign w_fs_en    = !r_failsafe;

    cycle_timer #(
        .LIMIT (BYTE_TIMEOUT_CYC)
    ) u_byte_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (rx_valid),
        .i_en  (w_byte_en),
        .o_tc  (w_byte_tc)
    );

    cycle_timer #(
        .LIMIT (FAILSAFE_CYC)
    ) u_failsafe_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_fs_en),
        .o_tc  (w_fs_tc)
    );

    // Frame state machine: header match, payload capture, checksum verdict
    // and inter-byte timeout abort. Payload bytes are never header-matched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= H0;
            r_steer_buf   <= '0;
            r_thr_buf     <= '0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    H0: begin
                        if (rx_data == HDR0) r_state <= H1;
                        else                 r_state <= H0;
                    end
                    H1: begin
                        if (rx_data == HDR1)      r_state <= H2;
                        else if (rx_data == HDR0) r_state <= H1;
                        else                      r_state <= H0;
                    end
                    H2: begin
                        if (rx_data == HDR2)      r_state <= SH;
                        else if (rx_data == HDR0) r_state <= H1;
                        else                      r_state <= H0;
                    end
                    SH: begin
                        r_steer_buf[15:8] <= rx_data;
                        r_state           <= SL;
                    end
                    SL: begin
                        r_steer_buf[7:0] <= rx_data;
                        r_state          <= TH;
                    end
                    TH: begin
                        r_thr_buf[15:8] <= rx_data;
                        r_state         <= TL;
                    end
                    TL: begin
                        r_thr_buf[7:0] <= rx_data;
                        r_state        <= CK;
                    end
                    CK: begin
                        r_frame_err <= w_reject;
                        r_state     <= H0;
                    end
                    default: r_state <= H0;
                endcase
            end else if (w_byte_tc) begin
                r_state       <= H0;
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Command outputs: a good frame loads the buffers; otherwise failsafe
    // expiry forces neutral. The timer's clear already gives a simultaneous
    // good frame priority over expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steer      <= STEER_NEUTRAL;
            r_throttle   <= THR_NEUTRAL;
            r_cmd_update <= 1'b0;
            r_failsafe   <= 1'b1;
        end else begin
            r_cmd_update <= 1'b0;
            if (w_accept) begin
                r_steer      <= r_steer_buf;
                r_throttle   <= r_thr_buf;
                r_cmd_update <= 1'b1;
                r_failsafe   <= 1'b0;
            end else if (w_fs_tc) begin
                r_steer      <= STEER_NEUTRAL;
                r_throttle   <= THR_NEUTRAL;
                r_cmd_update <= 1'b1;
                r_failsafe   <= 1'b1;
            end
        end
    end

    assign steer       = r_steer;
    assign throttle    = r_throttle;
    assign cmd_update  = r_cmd_update;
    assign frame_err   = r_frame_err;
    assign timeout_err = r_timeout_err;
    assign failsafe    = r_failsafe;

endmodule

// File: tb/tb_rc_frame_parser.sv
// Bench for rc_frame_parser: directed scenarios plus randomized traffic,
// checked every cycle against a byte-level behavioural model.
`timescale 1ns/1ps
module tb_rc_frame_parser;

    localparam int BT = 100;
    localparam int FS = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] steer;
    logic [15:0] throttle;
    logic        cmd_update;
    logic        frame_err;
    logic        timeout_err;
    logic        failsafe;

    rc_frame_parser #(
        .BYTE_TIMEOUT_CYC (32'd100),
        .FAILSAFE_CYC     (32'd1000),
        .STEER_MAX        (16'd2000),
        .THR_MAX          (16'd1023)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .steer       (steer),
        .throttle    (throttle),
        .cmd_update  (cmd_update),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .failsafe    (failsafe)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt_cmd = 0, cnt_ferr = 0, cnt_terr = 0;

    // ---------------- behavioural model ----------------
    int          m_n = 0;      // bytes of the current frame collected
    int          m_idle = 0;   // idle cycles since last byte of an open frame
    int          m_fsc = 0;    // cycles since last good frame
    logic [7:0]  m_frm [8];
    logic [7:0]  m_hdr [3] = '{8'h61, 8'h62, 8'h63};
    logic [15:0] m_steer = 16'd500;
    logic [15:0] m_thr = 16'd512;
    logic        m_fs = 1'b1, m_cmd = 1'b0, m_ferr = 1'b0, m_terr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ck(input logic [15:0] s, input logic [15:0] t);
        return s[15:8] ^ s[7:0] ^ t[15:8] ^ t[7:0];
    endfunction

    task automatic model_reset();
        m_n = 0; m_idle = 0; m_fsc = 0;
        m_steer = 16'd500; m_thr = 16'd512;
        m_fs = 1'b1; m_cmd = 1'b0; m_ferr = 1'b0; m_terr = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] s, t;
        logic acc;
        acc = 1'b0; s = '0; t = '0;
        m_cmd = 1'b0; m_ferr = 1'b0; m_terr = 1'b0;
        if (rx_valid) begin
            m_idle = 0;
            if (m_n < 3) begin
                if (rx_data == m_hdr[m_n]) m_n = m_n + 1;
                else if (rx_data == 8'h61) m_n = 1;
                else m_n = 0;
            end else begin
                m_frm[m_n] = rx_data;
                m_n = m_n + 1;
                if (m_n == 8) begin
                    s = {m_frm[3], m_frm[4]};
                    t = {m_frm[5], m_frm[6]};
                    if ((ck(s, t) == m_frm[7]) && (s <= 16'd2000) && (t <= 16'd1023)) acc = 1'b1;
                    else m_ferr = 1'b1;
                    m_n = 0;
                end
            end
        end else if (m_n != 0) begin
            m_idle = m_idle + 1;
            if (m_idle == BT) begin
                m_n = 0; m_idle = 0; m_terr = 1'b1;
            end
        end
        if (acc) begin
            m_steer = s; m_thr = t; m_cmd = 1'b1; m_fs = 1'b0; m_fsc = 0;
        end else if (!m_fs) begin
            m_fsc = m_fsc + 1;
            if (m_fsc == FS) begin
                m_fs = 1'b1; m_steer = 16'd500; m_thr = 16'd512; m_cmd = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("steer", 32'(steer), 32'(m_steer));
        check("throttle", 32'(throttle), 32'(m_thr));
        check("cmd_update", 32'(cmd_update), 32'(m_cmd));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        check("failsafe", 32'(failsafe), 32'(m_fs));
        if (cmd_update)  cnt_cmd++;
        if (frame_err)   cnt_ferr++;
        if (timeout_err) cnt_terr++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_frame(input logic [15:0] s, input logic [15:0] t,
                              input logic [7:0] c, input int gap);
        logic [7:0] b [8];
        b = '{8'h61, 8'h62, 8'h63, s[15:8], s[7:0], t[15:8], t[7:0], c};
        for (int i = 0; i < 8; i++) send_byte(b[i], (i == 7) ? 0 : gap);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int snap;
        logic [15:0] rs, rt;
        logic [7:0]  rc, rmask;
        int kind, gap;

        rst_n = 1'b0;
        idle(3);
        check("rst_steer", 32'(steer), 500);
        check("rst_throttle", 32'(throttle), 512);
        check("rst_failsafe", 32'(failsafe), 1);
        check("rst_cmd_update", 32'(cmd_update), 0);
        rst_n = 1'b1;
        idle(2);

        // Bad checksum before any good frame
        snap = cnt_ferr;
        send_frame(16'h01F4, 16'h0200, 8'h00, 0);
        idle(2);
        check("badck_ferr_cnt", 32'(cnt_ferr - snap), 1);
        check("badck_failsafe", 32'(failsafe), 1);

        // Good frame: outputs load one cycle after the checksum byte
        send_frame(16'h01F4, 16'h0200, 8'hF7, 0);
        check("good_steer", 32'(steer), 500);
        check("good_throttle", 32'(throttle), 512);
        check("good_cmd_update", 32'(cmd_update), 1);
        check("good_failsafe", 32'(failsafe), 0);
        idle(1);
        check("good_cmd_pulse_len", 32'(cmd_update), 0);

        // Resync on "xaabc"
        send_byte(8'h78, 0);
        send_byte(8'h61, 0);
        send_frame(16'h03E8, 16'h0300, 8'hE8, 0);
        check("resync_steer", 32'(steer), 1000);
        check("resync_throttle", 32'(throttle), 768);

        // Inter-byte timeout after "abc",0x01
        snap = cnt_terr;
        send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 0); send_byte(8'h01, 0);
        idle(99);
        check("timeout_not_yet", 32'(timeout_err), 0);
        idle(1);
        check("timeout_at_100", 32'(timeout_err), 1);
        idle(50);
        check("timeout_cnt", 32'(cnt_terr - snap), 1);
        send_frame(16'h01F4, 16'h0200, 8'hF7, 0);
        check("after_timeout_steer", 32'(steer), 500);

        // Failsafe expiry
        send_frame(16'h03E8, 16'h0300, 8'hE8, 0);
        idle(999);
        check("fs_not_yet", 32'(failsafe), 0);
        snap = cnt_cmd;
        idle(1);
        check("fs_failsafe", 32'(failsafe), 1);
        check("fs_steer", 32'(steer), 500);
        check("fs_throttle", 32'(throttle), 512);
        idle(50);
        check("fs_single_update", 32'(cnt_cmd - snap), 1);
        send_frame(16'h03E8, 16'h0300, 8'hE8, 0);
        check("fs_cleared", 32'(failsafe), 0);

        // Range rejects
        snap = cnt_ferr;
        send_frame(16'h07D1, 16'h0200, 8'hD4, 0);
        send_frame(16'h01F4, 16'h0400, 8'hF1, 0);
        idle(2);
        check("range_ferr_cnt", 32'(cnt_ferr - snap), 2);
        check("range_steer_kept", 32'(steer), 1000);

        // Header byte inside payload is data; inclusive range limits
        send_frame(16'h0061, 16'h0061, 8'h00, 0);
        check("payload_a_steer", 32'(steer), 97);
        send_frame(16'h07D0, 16'h03FF, 8'h2B, 0);
        check("max_steer", 32'(steer), 2000);
        check("max_throttle", 32'(throttle), 1023);

        // Gap of 99 idle cycles between bytes is still one frame
        send_frame(16'h0100, 16'h0100, ck(16'h0100, 16'h0100), 99);
        check("gap99_steer", 32'(steer), 256);

        // Good frame lands on the failsafe expiry cycle
        idle(992);
        snap = cnt_cmd;
        send_frame(16'h0123, 16'h0145, ck(16'h0123, 16'h0145), 0);
        idle(3);
        check("simul_failsafe", 32'(failsafe), 0);
        check("simul_steer", 32'(steer), 32'h123);
        check("simul_updates", 32'(cnt_cmd - snap), 1);

        // Reset in the middle of a frame
        send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 0); send_byte(8'h02, 0);
        #3 rst_n = 1'b0;
        #5;
        check("midrst_steer", 32'(steer), 500);
        check("midrst_failsafe", 32'(failsafe), 1);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_frame(16'h0200, 16'h0010, ck(16'h0200, 16'h0010), 0);
        check("midrst_next_steer", 32'(steer), 512);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 9));
            rs = 16'($urandom_range(0, 2100));
            rt = 16'($urandom_range(0, 1100));
            rc = ck(rs, rt);
            if (kind == 0) begin
                rmask = 8'h01 << $urandom_range(0, 7);
                rc = rc ^ rmask;
            end
            if (kind == 1) send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
            gap = (kind == 2) ? int'($urandom_range(95, 110)) : int'($urandom_range(0, 2));
            send_frame(rs, rt, rc, gap);
            if (kind == 3) idle(int'($urandom_range(900, 1100)));
            else idle(int'($urandom_range(0, 5)));
        end

        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
